// File: rtl/writeback_arbiter.sv
// Register-file write-port master: merges WB-stage writes with buffered MDU results
// and keeps the busy scoreboard for outstanding MDU destinations.
module writeback_arbiter #(
  parameter int DEPTH        = 4,
  parameter int STARVE_LIMIT = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        wb_we,
  input  logic [4:0]  wb_rd,
  input  logic [31:0] wb_data,
  input  logic        md_valid,
  input  logic [4:0]  md_rd,
  input  logic [31:0] md_data,
  output logic        md_ready,
  input  logic        iss_valid,
  input  logic [4:0]  iss_rd,
  input  logic [4:0]  lk_rs,
  input  logic [4:0]  lk_rt,
  input  logic [4:0]  lk_rd,
  output logic        busy_rs,
  output logic        busy_rt,
  output logic        busy_rd,
  output logic        wb_stall,
  output logic        rf_we,
  output logic [4:0]  rf_waddr,
  output logic [31:0] rf_wdata
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(STARVE_LIMIT + 1);

  logic [4:0]    rd_mem_q   [DEPTH];
  logic [4:0]    rd_mem_d   [DEPTH];
  logic [31:0]   data_mem_q [DEPTH];
  logic [31:0]   data_mem_d [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW:0]   count_q, count_d;
  logic [CW-1:0] starve_q, starve_d;
  logic [31:0]   busy_q, busy_d;
  logic          wb_stall_q, wb_stall_d;

  logic head_vld, wb_act, commit, push, blocked;

  assign head_vld = (count_q != '0);
  assign wb_act   = wb_we && (wb_rd != 5'd0) && !wb_stall_q;
  assign commit   = !reset && head_vld && !wb_act;
  assign md_ready = reset || (count_q != (AW+1)'(DEPTH));
  // Results for r0 are acknowledged to the MDU but never stored.
  assign push     = md_valid && md_ready && (md_rd != 5'd0);
  assign blocked  = head_vld && wb_act;
  assign wb_stall = wb_stall_q;

  assign busy_rs = !reset && busy_q[lk_rs];
  assign busy_rt = !reset && busy_q[lk_rt];
  assign busy_rd = !reset && busy_q[lk_rd];

  always_comb begin
    rf_we    = 1'b0;
    rf_waddr = 5'd0;
    rf_wdata = 32'd0;
    if (!reset) begin
      if (wb_act) begin
        rf_we    = 1'b1;
        rf_waddr = wb_rd;
        rf_wdata = wb_data;
      end else if (head_vld) begin
        rf_we    = 1'b1;
        rf_waddr = rd_mem_q[rd_ptr_q];
        rf_wdata = data_mem_q[rd_ptr_q];
      end
    end
  end

  always_comb begin
    rd_mem_d   = rd_mem_q;
    data_mem_d = data_mem_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    if (push) begin
      rd_mem_d[wr_ptr_q]   = md_rd;
      data_mem_d[wr_ptr_q] = md_data;
      wr_ptr_d             = wr_ptr_q + 1'b1;
    end
    if (commit) rd_ptr_d = rd_ptr_q + 1'b1;
    case ({push, commit})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  // Starvation: after STARVE_LIMIT blocked cycles the pipeline is frozen once so the head drains.
  always_comb begin
    starve_d   = blocked ? starve_q + 1'b1 : '0;
    wb_stall_d = blocked && (starve_q == CW'(STARVE_LIMIT - 1));
  end

  // Set is applied after clear so a same-cycle issue to the committing register wins.
  always_comb begin
    busy_d = busy_q;
    if (commit) busy_d[rd_mem_q[rd_ptr_q]] = 1'b0;
    if (iss_valid && (iss_rd != 5'd0)) busy_d[iss_rd] = 1'b1;
  end

  always_ff @(posedge clk) begin
    rd_mem_q   <= rd_mem_d;
    data_mem_q <= data_mem_d;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      starve_q   <= '0;
      busy_q     <= '0;
      wb_stall_q <= 1'b0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      starve_q   <= starve_d;
      busy_q     <= busy_d;
      wb_stall_q <= wb_stall_d;
    end
  end

endmodule

// File: tb/tb_writeback_arbiter.sv
// Directed bench for writeback_arbiter: arbitration, FIFO, starvation stall, scoreboard, reset.
module tb_writeback_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic        wb_we;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data;
  logic        md_valid;
  logic [4:0]  md_rd;
  logic [31:0] md_data;
  logic        md_ready;
  logic        iss_valid;
  logic [4:0]  iss_rd;
  logic [4:0]  lk_rs, lk_rt, lk_rd;
  logic        busy_rs, busy_rt, busy_rd;
  logic        wb_stall;
  logic        rf_we;
  logic [4:0]  rf_waddr;
  logic [31:0] rf_wdata;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  writeback_arbiter #(.DEPTH(4), .STARVE_LIMIT(8)) dut (
    .clk(clk), .reset(reset),
    .wb_we(wb_we), .wb_rd(wb_rd), .wb_data(wb_data),
    .md_valid(md_valid), .md_rd(md_rd), .md_data(md_data), .md_ready(md_ready),
    .iss_valid(iss_valid), .iss_rd(iss_rd),
    .lk_rs(lk_rs), .lk_rt(lk_rt), .lk_rd(lk_rd),
    .busy_rs(busy_rs), .busy_rt(busy_rt), .busy_rd(busy_rd),
    .wb_stall(wb_stall),
    .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Advance to just after the next rising edge; inputs are then changed and checked #1 later.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic port(input string tag, input logic we, input logic [4:0] a, input logic [31:0] d);
    chk({tag, ".we"}, 32'(rf_we), 32'(we));
    chk({tag, ".waddr"}, 32'(rf_waddr), 32'(a));
    chk({tag, ".wdata"}, rf_wdata, d);
  endtask

  initial begin
    reset = 1'b1; wb_we = 1'b1; wb_rd = 5'd3; wb_data = 32'h33;
    md_valid = 1'b0; md_rd = 5'd0; md_data = 32'd0;
    iss_valid = 1'b0; iss_rd = 5'd0;
    lk_rs = 5'd0; lk_rt = 5'd0; lk_rd = 5'd0;
    #2;
    port("rst_port", 1'b0, 5'd0, 32'd0);
    chk("rst_md_ready", 32'(md_ready), 32'd1);
    tick(); tick();
    chk("rst_stall", 32'(wb_stall), 32'd0);

    // Idle after reset
    reset = 1'b0; wb_we = 1'b0; wb_rd = 5'd0; wb_data = 32'd0;
    lk_rs = 5'd5; lk_rt = 5'd7; lk_rd = 5'd9;
    #1;
    port("idle", 1'b0, 5'd0, 32'd0);
    chk("idle_md_ready", 32'(md_ready), 32'd1);
    chk("idle_busy", {29'd0, busy_rs, busy_rt, busy_rd}, 32'd0);
    chk("idle_stall", 32'(wb_stall), 32'd0);

    // Issue rd=5, MDU returns 0xDEADBEEF one cycle after accept
    lk_rd = 5'd5; iss_valid = 1'b1; iss_rd = 5'd5;
    tick();
    iss_valid = 1'b0; iss_rd = 5'd0;
    #1;
    chk("iss5_busy", 32'(busy_rd), 32'd1);
    md_valid = 1'b1; md_rd = 5'd5; md_data = 32'hDEADBEEF;
    #1;
    chk("md5_no_bypass", 32'(rf_we), 32'd0);
    tick();
    md_valid = 1'b0; md_rd = 5'd0; md_data = 32'd0;
    #1;
    port("md5_commit", 1'b1, 5'd5, 32'hDEADBEEF);
    chk("md5_busy_held", 32'(busy_rd), 32'd1);
    tick();
    chk("md5_busy_clr", 32'(busy_rd), 32'd0);
    chk("md5_empty", 32'(rf_we), 32'd0);

    // WB write has priority over a queued result
    md_valid = 1'b1; md_rd = 5'd7; md_data = 32'h77;
    tick();
    md_valid = 1'b0; md_rd = 5'd0; md_data = 32'd0;
    wb_we = 1'b1; wb_rd = 5'd3; wb_data = 32'h11;
    #1;
    port("wb_prio", 1'b1, 5'd3, 32'h11);
    tick();
    wb_we = 1'b0; wb_rd = 5'd0; wb_data = 32'd0;
    #1;
    port("md7_commit", 1'b1, 5'd7, 32'h77);
    tick();
    chk("md7_empty", 32'(rf_we), 32'd0);

    // Starvation: four pushes behind a continuous WB stream
    wb_we = 1'b1; wb_rd = 5'd4; wb_data = 32'h44;
    for (int i = 0; i < 4; i++) begin
      md_valid = 1'b1; md_rd = 5'(10 + i); md_data = 32'hA0 + 32'(i);
      tick();
    end
    md_valid = 1'b0; md_rd = 5'd0; md_data = 32'd0;
    #1;
    chk("full_md_ready", 32'(md_ready), 32'd0);
    chk("full_no_stall", 32'(wb_stall), 32'd0);
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("starve_no_stall", 32'(wb_stall), 32'd0);
      chk("starve_wb_addr", 32'(rf_waddr), 32'd4);
    end
    tick();
    chk("stall_on", 32'(wb_stall), 32'd1);
    port("stall_commit", 1'b1, 5'd10, 32'hA0);
    chk("stall_md_ready", 32'(md_ready), 32'd0);
    tick();
    chk("stall_off", 32'(wb_stall), 32'd0);
    chk("post_md_ready", 32'(md_ready), 32'd1);
    port("post_stall_wb", 1'b1, 5'd4, 32'h44);
    wb_we = 1'b0; wb_rd = 5'd0; wb_data = 32'd0;
    #1;
    port("drain11", 1'b1, 5'd11, 32'hA1);
    tick();
    port("drain12", 1'b1, 5'd12, 32'hA2);
    tick();
    port("drain13", 1'b1, 5'd13, 32'hA3);
    tick();
    chk("drain_empty", 32'(rf_we), 32'd0);

    // Result for r0 is dropped; wb_rd=0 is treated as idle
    md_valid = 1'b1; md_rd = 5'd0; md_data = 32'h55;
    tick();
    md_valid = 1'b0; md_data = 32'd0;
    #1;
    chk("r0_dropped", 32'(rf_we), 32'd0);
    md_valid = 1'b1; md_rd = 5'd8; md_data = 32'h88;
    tick();
    md_valid = 1'b0; md_rd = 5'd0; md_data = 32'd0;
    wb_we = 1'b1; wb_rd = 5'd0; wb_data = 32'h99;
    #1;
    port("wbrd0_commit", 1'b1, 5'd8, 32'h88);
    tick();
    wb_we = 1'b0; wb_data = 32'd0;
    #1;
    chk("wbrd0_empty", 32'(rf_we), 32'd0);

    // Same-cycle issue and commit of rd=9: set wins
    lk_rs = 5'd9; lk_rt = 5'd0;
    iss_valid = 1'b1; iss_rd = 5'd9;
    tick();
    iss_valid = 1'b0; iss_rd = 5'd0;
    md_valid = 1'b1; md_rd = 5'd9; md_data = 32'h90;
    tick();
    md_valid = 1'b0; md_rd = 5'd0; md_data = 32'd0;
    iss_valid = 1'b1; iss_rd = 5'd9;
    #1;
    port("r9_commit", 1'b1, 5'd9, 32'h90);
    tick();
    iss_valid = 1'b0; iss_rd = 5'd0;
    #1;
    chk("r9_set_wins", 32'(busy_rs), 32'd1);
    chk("r0_never_busy", 32'(busy_rt), 32'd0);

    // Reset with three results queued
    wb_we = 1'b1; wb_rd = 5'd1; wb_data = 32'h01;
    for (int i = 0; i < 3; i++) begin
      md_valid = 1'b1; md_rd = 5'(20 + i); md_data = 32'hC0 + 32'(i);
      tick();
    end
    md_valid = 1'b0; md_rd = 5'd0; md_data = 32'd0;
    wb_we = 1'b0; wb_rd = 5'd0; wb_data = 32'd0;
    reset = 1'b1;
    #1;
    port("rst_mid_port", 1'b0, 5'd0, 32'd0);
    chk("rst_mid_busy", 32'(busy_rs), 32'd0);
    tick();
    reset = 1'b0;
    #1;
    port("after_rst", 1'b0, 5'd0, 32'd0);
    chk("after_rst_busy", 32'(busy_rs), 32'd0);
    chk("after_rst_ready", 32'(md_ready), 32'd1);
    tick();
    chk("after_rst_idle", 32'(rf_we), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/writeback_arbiter.md
Name: writeback_arbiter

Overview:
- Write-side master for the register file's single write port.
- Merges in-order pipeline WB-stage writes with out-of-order results from the multi-cycle mul/div unit (MDU), which are buffered in a small FIFO.
- Keeps a per-register busy scoreboard for MDU destinations; the hazard unit uses it to stall RAW/WAW dependents.
- Drives the register file's regWrite/WriteRegister/WriteData directly.

Parameters:
- DEPTH, 4, MDU result FIFO entries (power of 2, ≥2).
- STARVE_LIMIT, 8, consecutive blocked cycles before the FIFO head forces a pipeline stall (≥1).

Ports:
- clk  in  1  clock; all state updates on posedge.
- reset  in  1  synchronous, active-high reset.
- wb_we  in  1  WB-stage write enable.
- wb_rd  in  5  WB-stage destination.
- wb_data  in  32  WB-stage data.
- md_valid  in  1  MDU result valid.
- md_rd  in  5  MDU result destination.
- md_data  in  32  MDU result data.
- md_ready  out  1  FIFO can accept (= count != DEPTH).
- iss_valid  in  1  MDU op issued this cycle.
- iss_rd  in  5  issued op's destination.
- lk_rs, lk_rt, lk_rd  in  5 each  scoreboard lookup addresses.
- busy_rs, busy_rt, busy_rd  out  1 each  busy[lk_*]; always 0 for address 0.
- wb_stall  out  1  registered; freezes the pipeline for one cycle.
- rf_we  out  1  to register file regWrite.
- rf_waddr  out  5  to WriteRegister.
- rf_wdata  out  32  to WriteData.

Behaviour:
- Reset: FIFO empty (pointers=0, count=0), busy[31:0]=0, starve counter=0, wb_stall=0.
  - Outputs during reset: md_ready=1, rf_we=0, busy_*=0, rf_waddr=0, rf_wdata=0.
- Write-port selection (combinational, zero latency; the register file's same-cycle bypass depends on this):
  - wb_act = wb_we && wb_rd!=0 && !wb_stall.
  - If wb_act: rf_we=1, rf_waddr=wb_rd, rf_wdata=wb_data.
  - Else if FIFO non-empty: rf_we=1, rf_waddr/rf_wdata = head entry; head pops at posedge ("commit").
  - Else rf_we=0, rf_waddr=0, rf_wdata=0.
- FIFO push:
  - Push on md_valid && md_ready.
  - md_rd==0 entries are accepted but dropped (never written, no commit).
  - No same-cycle bypass: an accepted result commits at the earliest one cycle later.
  - Push and pop in the same cycle: count unchanged.
  - Pointers wrap modulo DEPTH.
  - md_valid while full: not accepted; MDU must hold its result.
- Starvation:
  - Counter increments each cycle the FIFO is non-empty and wb_act=1; clears on any commit.
  - When the counter reaches STARVE_LIMIT-1 while still blocked, wb_stall=1 for exactly the next cycle.
  - In that cycle the WB inputs are ignored, the head commits, and the counter clears.
  - The frozen WB stage re-presents its write the following cycle; no write is lost or duplicated.
- Scoreboard:
  - iss_valid && iss_rd!=0 sets busy[iss_rd].
  - Committing a head entry clears busy[its rd].
  - Set and clear of the same register in the same cycle: set wins.
  - Setting an already-busy register is a hazard-unit violation; the bit simply stays 1.
  - busy_* reflect registered state (pre-edge).
  - A WB write to a busy register is still performed; the hazard unit must prevent that WAW ordering.
- Reset mid-operation: all buffered results are discarded; the MDU is reset by the same signal.

Test Plan:
- Reset, then idle: md_ready=1, rf_we=0, all busy_*=0, wb_stall=0.
- Issue rd=5, MDU returns rd=5/0xDEADBEEF with wb_we=0 → busy_rd(5)=1 until commit; rf_we=1, rf_waddr=5, rf_wdata=0xDEADBEEF exactly one cycle after accept; busy clears the next cycle.
- wb_we=1 rd=3/0x11 in the same cycle a result rd=7 sits in the FIFO → port writes rd=3 that cycle; rd=7 commits the next idle cycle.
- Push 4 results while wb_we=1 with nonzero rd continuously → md_ready=0 after the 4th; wb_stall=1 on cycle STARVE_LIMIT; head commits during the stall; md_ready returns to 1 the next cycle.
- md_rd=0 result pushed → no rf_we for it; FIFO count returns to 0. wb_rd=0 with wb_we=1 → treated as idle, so a FIFO head commits.
- Simultaneous iss_valid rd=9 and commit of rd=9 → busy[9]=1 afterwards; reset asserted with 3 entries queued → count=0, busy all 0, no further rf_we.
